// File: rtl/snake_move_sequencer.sv
// snake_move_sequencer: game FSM, move-tick prescaler, heading register and
// one-entry turn latch feeding a valid/ready step interface to the snake datapath.
`default_nettype none

module snake_move_sequencer #(
  parameter int               CNT_W     = 16,
  parameter logic [CNT_W-1:0] TICK_DIV  = CNT_W'(50000),
  parameter logic [CNT_W-1:0] MIN_DIV   = CNT_W'(10000),
  parameter logic [CNT_W-1:0] SPEED_DEC = CNT_W'(1000)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_cw,
  input  logic       btn_ccw,
  output logic       step_valid,
  output logic [1:0] step_dir,
  input  logic       step_ready,
  input  logic       step_done,
  input  logic       collision,
  input  logic       grew,
  output logic       running,
  output logic       paused,
  output logic       game_over,
  output logic [7:0] score
);

  localparam int EW = CNT_W + 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    STEP  = 3'd3,
    WAIT  = 3'd4,
    OVER  = 3'd5
  } state_t;

  state_t           state, state_next;
  logic [1:0]       heading;
  logic             pend_valid;
  logic             pend_cw;
  logic [CNT_W-1:0] presc;

  logic [EW-1:0]    prod;
  logic [EW-1:0]    diff;
  logic [EW-1:0]    period;
  logic             at_period;
  logic             start_game;
  logic             tick;
  logic             turn_ok;

  // Widened arithmetic so a large score cannot wrap the period back up.
  assign prod      = EW'(score) * EW'(SPEED_DEC);
  assign diff      = EW'(TICK_DIV) - prod;
  assign period    = ((prod > EW'(TICK_DIV)) || (diff < EW'(MIN_DIV))) ? EW'(MIN_DIV) : diff;
  assign at_period = (EW'(presc) >= (period - EW'(1)));

  always_comb begin
    state_next = state;
    start_game = 1'b0;
    tick       = 1'b0;
    turn_ok    = 1'b0;
    case (state)
      IDLE: begin
        if (btn_start) begin
          state_next = RUN;
          start_game = 1'b1;
        end
      end
      RUN: begin
        turn_ok = 1'b1;
        if (btn_pause) begin
          state_next = PAUSE;
        end else if (at_period) begin
          state_next = STEP;
          tick       = 1'b1;
        end
      end
      PAUSE: begin
        turn_ok = 1'b1;
        if (btn_start) begin
          state_next = RUN;
          start_game = 1'b1;
        end else if (btn_pause) begin
          state_next = RUN;
        end
      end
      STEP: begin
        turn_ok = 1'b1;
        if (step_ready) state_next = WAIT;
      end
      WAIT: begin
        turn_ok = 1'b1;
        if (step_done) state_next = collision ? OVER : RUN;
      end
      OVER: begin
        if (btn_start) begin
          state_next = RUN;
          start_game = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      step_valid <= 1'b0;
      running    <= 1'b0;
      paused     <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_next;
      step_valid <= (state_next == STEP);
      running    <= (state_next == RUN) || (state_next == STEP) || (state_next == WAIT);
      paused     <= (state_next == PAUSE);
      game_over  <= (state_next == OVER);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      heading    <= 2'b01;
      pend_valid <= 1'b0;
      pend_cw    <= 1'b0;
      presc      <= '0;
      score      <= 8'd0;
    end else if (start_game) begin
      heading    <= 2'b01;
      pend_valid <= 1'b0;
      presc      <= '0;
      score      <= 8'd0;
    end else begin
      if ((state == RUN) && !btn_pause) presc <= tick ? '0 : presc + CNT_W'(1);
      if (tick && pend_valid) begin
        heading    <= pend_cw ? heading + 2'd1 : heading - 2'd1;
        pend_valid <= 1'b0;
      end
      // A press in the tick cycle lands here after the apply, so it waits for the next step.
      if (turn_ok && (btn_cw ^ btn_ccw)) begin
        pend_valid <= 1'b1;
        pend_cw    <= btn_cw;
      end
      if ((state == WAIT) && step_done && !collision && grew && (score != 8'hFF))
        score <= score + 8'd1;
    end
  end

  assign step_dir = heading;

endmodule

`default_nettype wire

// File: tb/tb_snake_move_sequencer.sv
// tb_snake_move_sequencer: directed and randomized stimulus against a
// rule-level game model with an emulated datapath (done 2 cycles after accept).
`default_nettype none

module tb_snake_move_sequencer;

  localparam int TICK = 8;
  localparam int MIN  = 4;
  localparam int DEC  = 2;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_STEP  = 3;
  localparam int M_WAIT  = 4;
  localparam int M_OVER  = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_start, btn_pause, btn_cw, btn_ccw;
  logic       step_valid;
  logic [1:0] step_dir;
  logic       step_ready, step_done, collision, grew;
  logic       running, paused, game_over;
  logic [7:0] score;

  int vectors     = 0;
  int miscompares = 0;

  // reference model
  int md, cnt, hd, pend, sc;
  int dly;

  snake_move_sequencer #(
    .CNT_W    (16),
    .TICK_DIV (16'd8),
    .MIN_DIV  (16'd4),
    .SPEED_DEC(16'd2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_start (btn_start),
    .btn_pause (btn_pause),
    .btn_cw    (btn_cw),
    .btn_ccw   (btn_ccw),
    .step_valid(step_valid),
    .step_dir  (step_dir),
    .step_ready(step_ready),
    .step_done (step_done),
    .collision (collision),
    .grew      (grew),
    .running   (running),
    .paused    (paused),
    .game_over (game_over),
    .score     (score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    md = M_IDLE; cnt = 0; hd = 1; pend = 0; sc = 0; dly = 0;
  endtask

  task automatic model_step();
    int  pm, p;
    bit  start, turn;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pm    = md;
    start = btn_start && (pm == M_IDLE || pm == M_PAUSE || pm == M_OVER);
    turn  = (btn_cw != btn_ccw) && (pm == M_RUN || pm == M_STEP || pm == M_WAIT || pm == M_PAUSE);
    p     = TICK - sc * DEC;
    if (p < MIN) p = MIN;
    if (pm == M_STEP && step_ready) dly = 2;
    if (start) begin
      md = M_RUN; hd = 1; sc = 0; cnt = 0; pend = 0;
      return;
    end
    case (pm)
      M_RUN: begin
        if (btn_pause) md = M_PAUSE;
        else if (cnt == p - 1) begin
          cnt  = 0;
          hd   = (hd + pend + 4) % 4;
          pend = 0;
          md   = M_STEP;
        end else cnt++;
      end
      M_PAUSE: if (btn_pause) md = M_RUN;
      M_STEP:  if (step_ready) md = M_WAIT;
      M_WAIT: begin
        if (step_done) begin
          if (collision) md = M_OVER;
          else begin
            md = M_RUN;
            if (grew && sc < 255) sc++;
          end
        end
      end
      default: ;
    endcase
    if (turn) pend = btn_cw ? 1 : -1;
  endtask

  task automatic check_outputs();
    chk("step_valid", 32'(step_valid), 32'(md == M_STEP));
    chk("step_dir",   32'(step_dir),   32'(hd));
    chk("running",    32'(running),    32'(md == M_RUN || md == M_STEP || md == M_WAIT));
    chk("paused",     32'(paused),     32'(md == M_PAUSE));
    chk("game_over",  32'(game_over),  32'(md == M_OVER));
    chk("score",      32'(score),      32'(sc));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
    step_done = 1'b0;
    if (dly > 0) begin
      dly--;
      if (dly == 0) step_done = 1'b1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic press(input int which);
    btn_start = (which == 0);
    btn_pause = (which == 1);
    btn_cw    = (which == 2) || (which == 4);
    btn_ccw   = (which == 3) || (which == 4);
    cyc();
    btn_start = 1'b0; btn_pause = 1'b0; btn_cw = 1'b0; btn_ccw = 1'b0;
  endtask

  task automatic run_until(input int mode, input int budget, input string tag);
    int n;
    n = 0;
    while (md != mode && n < budget) begin
      cyc();
      n++;
    end
    chk({tag, "_reached"}, 32'(md == mode), 32'd1);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    btn_start = 1'b0; btn_pause = 1'b0; btn_cw = 1'b0; btn_ccw = 1'b0;
    step_ready = 1'b1; step_done = 1'b0; collision = 1'b0; grew = 1'b0;
    model_reset();
    run(3);
    rst_n = 1'b1;
    run(3);

    // start; first step 8 cycles after RUN entry, heading right
    press(0);
    chk("run_after_start", 32'(running), 32'd1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (step_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("first_latency", 32'(lat), 32'd8);
    chk("first_dir", 32'(step_dir), 32'd1);
    run_until(M_RUN, 20, "back_to_run");

    // turns: cw; ccw then cw (last wins); cw+ccw together ignored
    press(2);
    run_until(M_STEP, 20, "turn_cw");
    chk("dir_after_cw", 32'(step_dir), 32'd2);
    run_until(M_RUN, 20, "run2");
    press(3); run(1); press(2);
    run_until(M_STEP, 20, "turn_last_wins");
    chk("dir_last_wins", 32'(step_dir), 32'd3);
    run_until(M_RUN, 20, "run3");
    press(4);
    run_until(M_STEP, 20, "turn_both");
    chk("dir_both_ignored", 32'(step_dir), 32'd3);

    // growth shortens the period to the floor
    grew = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_until(M_WAIT, 20, "grow_wait");
      run_until(M_RUN, 20, "grow_run");
    end
    grew = 1'b0;
    chk("score_three", 32'(score), 32'd3);
    run(20);

    // backpressure: valid and dir held, single accept
    run_until(M_RUN, 20, "bp_run");
    step_ready = 1'b0;
    run_until(M_STEP, 20, "bp_step");
    run(5);
    step_ready = 1'b1;
    run(12);

    // pause mid-count at prescaler 3
    run_until(M_RUN, 20, "pause_run");
    lat = 0;
    while (!(md == M_RUN && cnt == 3) && lat < 40) begin
      cyc();
      lat++;
    end
    press(1);
    chk("paused_flag", 32'(paused), 32'd1);
    run(7);
    press(1);
    run(12);

    // randomized phase
    for (int i = 0; i < 800; i++) begin
      btn_start  = ($urandom % 40) == 0;
      btn_pause  = ($urandom % 25) == 0;
      btn_cw     = ($urandom % 6) == 0;
      btn_ccw    = ($urandom % 6) == 0;
      step_ready = ($urandom % 4) != 0;
      grew       = ($urandom % 3) == 0;
      collision  = ($urandom % 30) == 0;
      cyc();
    end
    btn_start = 1'b0; btn_pause = 1'b0; btn_cw = 1'b0; btn_ccw = 1'b0;
    step_ready = 1'b1; grew = 1'b0; collision = 1'b0;
    run(10);

    // saturate score at 255
    if (md != M_RUN && md != M_STEP && md != M_WAIT) press(0);
    grew = 1'b1;
    lat = 0;
    while (sc < 255 && lat < 6000) begin
      cyc();
      lat++;
    end
    run(30);
    grew = 1'b0;
    chk("score_saturated", 32'(score), 32'd255);

    // collision ends the game; turns and steps stop
    collision = 1'b1;
    run_until(M_OVER, 40, "collide");
    collision = 1'b0;
    chk("game_over_flag", 32'(game_over), 32'd1);
    press(2); run(3); press(3);
    run(20);
    press(0);
    chk("restart_running", 32'(running), 32'd1);
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_dir", 32'(step_dir), 32'd1);

    // asynchronous reset while a step is offered
    step_ready = 1'b0;
    run_until(M_STEP, 20, "async_step");
    run(2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    step_done = 1'b0;
    check_outputs();
    cyc();
    rst_n = 1'b1;
    step_ready = 1'b1;
    run(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
